// File: rtl/rs232_pkg.sv
// Shared definitions for the QuickRS232 serial blocks (transmitter today,
// receiver later): FSM state encoding, default bit timing and a parity helper.
package rs232_pkg;

  // Frame sequencing states; the numeric codes are fixed so both directions
  // of the link report states identically.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    FETCH  = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } rs232_state_e;

  // 50 MHz system clock divided down to 115200 baud.
  localparam int DEFAULT_BAUD_DIVISOR = 434;

  // Widest data word the parity helper accepts; narrower words are
  // zero-extended, which leaves the XOR unchanged.
  localparam int PARITY_MAX_WIDTH = 16;

  // Even parity bit: XOR of all data bits.
  function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Baud-rate tick generator shared by the RS-232 transmitter and receiver.
// Counts 0..BAUD_DIVISOR-1 and emits a one-cycle tick on the last count,
// so each tick marks the final cycle of a serial bit period.
module rs232_baud_tick
  import rs232_pkg::*;
#(
  parameter int BAUD_DIVISOR = DEFAULT_BAUD_DIVISOR
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(BAUD_DIVISOR);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BAUD_DIVISOR - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: hold at zero while cleared, otherwise wrap at each bit boundary.
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear_i || (count_q == LAST_COUNT)) begin
      count_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/rs232_transmitter.sv
// QuickRS232 serial transmitter. Pops bytes from the upstream fifo and sends
// each as start bit, LSB-first data, optional even parity, then stop bit(s).
// Optional feature macro: RS232_TX_PARITY_EN adds an even-parity bit after
// the data bits; without it the frame goes straight from data to stop.
module rs232_transmitter
  import rs232_pkg::*;
#(
  parameter int BAUD_DIVISOR = DEFAULT_BAUD_DIVISOR,
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  pop_clock,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  // One index counter walks the data bits and then the stop bits.
  localparam int IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(STOP_BITS - 1);

  rs232_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      bitIdx_q, bitIdx_d;
  logic                  tx_q, tx_d;
  logic                  pop_q, pop_d;
  logic                  baudTick;
  logic                  baudClear;
`ifdef RS232_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // Hold the baud counter at zero until the start bit so every frame begins
  // with a full-length start bit.
  assign baudClear = (state_q == IDLE) || (state_q == POP) || (state_q == FETCH);

  rs232_baud_tick #(
    .BAUD_DIVISOR(BAUD_DIVISOR)
  ) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(baudClear),
    .tick_o (baudTick)
  );

  // Frame sequencing; tx and pop_clock are derived from the next state so
  // both come straight out of flops aligned with the state register.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitIdx_d = bitIdx_q;
`ifdef RS232_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = POP;
        end
      end
      POP: begin
        state_d = FETCH;
      end
      FETCH: begin
        state_d  = START;
        shift_d  = fifo_data;
        bitIdx_d = '0;
`ifdef RS232_TX_PARITY_EN
        parity_d = even_parity(PARITY_MAX_WIDTH'(fifo_data));
`endif
      end
      START: begin
        if (baudTick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (baudTick) begin
          shift_d = shift_q >> 1;
          if (bitIdx_q == LAST_DATA_IDX) begin
            bitIdx_d = '0;
`ifdef RS232_TX_PARITY_EN
            state_d  = PARITY;
`else
            state_d  = STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + IDX_W'(1);
          end
        end
      end
`ifdef RS232_TX_PARITY_EN
      PARITY: begin
        if (baudTick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baudTick) begin
          if (bitIdx_q == LAST_STOP_IDX) begin
            bitIdx_d = '0;
            state_d  = IDLE;
          end else begin
            bitIdx_d = bitIdx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pop_d = (state_d == POP);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef RS232_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitIdx_q <= '0;
      tx_q     <= 1'b1;
      pop_q    <= 1'b0;
`ifdef RS232_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitIdx_q <= bitIdx_d;
      tx_q     <= tx_d;
      pop_q    <= pop_d;
`ifdef RS232_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign pop_clock  = pop_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && baudTick && (bitIdx_q == LAST_STOP_IDX);

endmodule

// File: tb/tb_rs232_transmitter.sv
// Testbench for rs232_transmitter: a queue-based fifo model feeds the DUT and
// an expected per-cycle waveform of {tx, busy, pop_clock, frame_done} is built
// from the frame layout (gap cycles, start, data LSB first, parity, stops).
module tb_rs232_transmitter;

  localparam int BAUD = 4;
  localparam int DW   = 8;
  localparam int SB   = 1;
`ifdef RS232_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME_BITS = 1 + DW + PBITS + SB;
  localparam int FRAME_CYC  = FRAME_BITS * BAUD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          pop_clock;
  logic          tx;
  logic          busy;
  logic          frame_done;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] fifoQ[$];
  logic          popPrev = 1'b0;
  logic [3:0]    expQ[$];

  always #5 clk = ~clk;

  rs232_transmitter #(
    .BAUD_DIVISOR(BAUD),
    .DATA_WIDTH  (DW),
    .STOP_BITS   (SB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .pop_clock (pop_clock),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // Advance to the next falling edge and act as the fifo: a rising pop_clock
  // presents the next byte on fifo_data and updates the empty flag.
  task automatic nextCycle();
    @(negedge clk);
    if (pop_clock && !popPrev && (fifoQ.size() > 0)) begin
      fifo_data = fifoQ.pop_front();
    end
    popPrev    = pop_clock;
    fifo_empty = (fifoQ.size() == 0);
  endtask

  task automatic loadByte(input logic [DW-1:0] b);
    fifoQ.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // Expected tx value of bit position k of a frame carrying byte b.
  function automatic logic frameBit(input logic [DW-1:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return b[k-1];
    if ((PBITS == 1) && (k == DW + 1)) return ^b;
    return 1'b1;
  endfunction

  // One byte: IDLE, POP, FETCH cycles then the frame, each bit BAUD cycles.
  task automatic appendFrame(input logic [DW-1:0] b);
    expQ.push_back(4'b1000);
    expQ.push_back(4'b1110);
    expQ.push_back(4'b1100);
    for (int k = 0; k < FRAME_BITS; k++) begin
      for (int j = 0; j < BAUD; j++) begin
        expQ.push_back({frameBit(b, k), 1'b1, 1'b0,
                        ((k == FRAME_BITS - 1) && (j == BAUD - 1)) ? 1'b1 : 1'b0});
      end
    end
  endtask

  task automatic appendIdle(input int n);
    for (int i = 0; i < n; i++) expQ.push_back(4'b1000);
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    enable     = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    repeat (3) nextCycle();
    compared++;
    if (tx !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_tx got=%b exp=1", tx); end
    compared++;
    if (pop_clock !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_pop got=%b exp=0", pop_clock); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    compared++;
    if (frame_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got=%b exp=0", frame_done); end
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (2) nextCycle();
  endtask

  task automatic test_single_frame(input logic [DW-1:0] b);
    logic [3:0] obs;
    int pops = 0, busyCnt = 0, doneCnt = 0;
    expQ.delete();
    loadByte(b);
    appendFrame(b);
    appendIdle(8);
    for (int c = 0; c < expQ.size(); c++) begin
      obs = {tx, busy, pop_clock, frame_done};
      compared++;
      if (obs !== expQ[c]) begin
        mismatched++;
        $display("[TB] FAIL single_wave byte=%h cyc=%0d got=%b exp=%b", b, c, obs, expQ[c]);
      end
      pops    += int'(pop_clock);
      busyCnt += int'(busy);
      doneCnt += int'(frame_done);
      nextCycle();
    end
    compared++;
    if (pops !== 1) begin mismatched++; $display("[TB] FAIL single_pops byte=%h got=%0d exp=1", b, pops); end
    compared++;
    if (busyCnt !== 2 + FRAME_CYC) begin
      mismatched++; $display("[TB] FAIL single_busy byte=%h got=%0d exp=%0d", b, busyCnt, 2 + FRAME_CYC);
    end
    compared++;
    if (doneCnt !== 1) begin mismatched++; $display("[TB] FAIL single_done byte=%h got=%0d exp=1", b, doneCnt); end
  endtask

  task automatic test_back_to_back(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                                   input logic [DW-1:0] b2);
    logic [3:0] obs;
    int pops = 0;
    expQ.delete();
    loadByte(b0);
    loadByte(b1);
    loadByte(b2);
    appendFrame(b0);
    appendFrame(b1);
    appendFrame(b2);
    appendIdle(6);
    for (int c = 0; c < expQ.size(); c++) begin
      obs = {tx, busy, pop_clock, frame_done};
      compared++;
      if (obs !== expQ[c]) begin
        mismatched++;
        $display("[TB] FAIL b2b_wave cyc=%0d got=%b exp=%b", c, obs, expQ[c]);
      end
      pops += int'(pop_clock);
      nextCycle();
    end
    compared++;
    if (pops !== 3) begin mismatched++; $display("[TB] FAIL b2b_pops got=%0d exp=3", pops); end
  endtask

  task automatic test_empty_idle();
    int popSeen = 0, txLow = 0, busySeen = 0;
    for (int c = 0; c < 1000; c++) begin
      popSeen  += int'(pop_clock);
      txLow    += int'(!tx);
      busySeen += int'(busy);
      nextCycle();
    end
    compared++;
    if (popSeen !== 0) begin mismatched++; $display("[TB] FAIL empty_pop got=%0d exp=0", popSeen); end
    compared++;
    if (txLow !== 0) begin mismatched++; $display("[TB] FAIL empty_tx_low got=%0d exp=0", txLow); end
    compared++;
    if (busySeen !== 0) begin mismatched++; $display("[TB] FAIL empty_busy got=%0d exp=0", busySeen); end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] b = 8'hAC;
    int txLow = 0, busySeen = 0, popSeen = 0;
    loadByte(b);
    repeat (3 + BAUD + 3 * BAUD + 1) nextCycle();
    compared++;
    if ({tx, busy} !== {b[3], 1'b1}) begin
      mismatched++; $display("[TB] FAIL midreset_pre got=%b%b exp=%b1", tx, busy, b[3]);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (tx !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_tx got=%b exp=1", tx); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy); end
    repeat (2) nextCycle();
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      txLow    += int'(!tx);
      busySeen += int'(busy);
      popSeen  += int'(pop_clock);
      nextCycle();
    end
    compared++;
    if ({txLow, busySeen, popSeen} !== {32'd0, 32'd0, 32'd0}) begin
      mismatched++;
      $display("[TB] FAIL postreset_idle txLow=%0d busy=%0d pops=%0d exp=0/0/0", txLow, busySeen, popSeen);
    end
  endtask

  task automatic test_enable_drop(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                                  input logic [DW-1:0] b2);
    logic [3:0] obs;
    int pops = 0;
    expQ.delete();
    loadByte(b0);
    loadByte(b1);
    loadByte(b2);
    appendFrame(b0);
    appendIdle(20);
    for (int c = 0; c < expQ.size(); c++) begin
      obs = {tx, busy, pop_clock, frame_done};
      compared++;
      if (obs !== expQ[c]) begin
        mismatched++;
        $display("[TB] FAIL endrop_wave cyc=%0d got=%b exp=%b", c, obs, expQ[c]);
      end
      pops += int'(pop_clock);
      if (c == 3 + BAUD + 2 * BAUD) enable = 1'b0;
      nextCycle();
    end
    compared++;
    if (pops !== 1) begin mismatched++; $display("[TB] FAIL endrop_pops got=%0d exp=1", pops); end
    enable = 1'b1;
    pops = 0;
    expQ.delete();
    appendFrame(b1);
    appendFrame(b2);
    appendIdle(5);
    for (int c = 0; c < expQ.size(); c++) begin
      obs = {tx, busy, pop_clock, frame_done};
      compared++;
      if (obs !== expQ[c]) begin
        mismatched++;
        $display("[TB] FAIL enresume_wave cyc=%0d got=%b exp=%b", c, obs, expQ[c]);
      end
      pops += int'(pop_clock);
      nextCycle();
    end
    compared++;
    if (pops !== 2) begin mismatched++; $display("[TB] FAIL enresume_pops got=%0d exp=2", pops); end
  endtask

  initial begin
    test_reset();
    test_single_frame(8'hAC);
    test_single_frame(8'h61);
    for (int i = 0; i < 3; i++) test_single_frame(DW'($urandom));
    test_back_to_back(8'hAC, 8'h61, DW'($urandom));
    test_back_to_back(DW'($urandom), DW'($urandom), DW'($urandom));
    test_empty_idle();
    test_reset_mid_frame();
    test_enable_drop(DW'($urandom), DW'($urandom), DW'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
